// File: rtl/alu_div_seq_if.sv
// Handshake bundle for the iterative RV32M divider: op request side and result side.
interface alu_div_seq_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [31:0]     inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, in_a, in_b, inst, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, inst, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: skip the loop when the divisor is zero or exceeds the dividend.
module alu_div_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    alu_div_seq_if.slave dif
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   a_raw, abs_b, quo, rem;
    logic [CNT_W-1:0]  cnt;
    logic              q_neg, r_neg, b_zero, want_rem;

    logic [2:0]        func3;
    logic              is_signed, accept, skip;
    logic [XLEN-1:0]   abs_a_in, abs_b_in;
    logic [XLEN:0]     diff;

    assign func3     = dif.inst[14:12];
    assign is_signed = ~func3[0];
    assign accept    = dif.in_valid && (state_q == S_IDLE) && !flush;
    assign abs_a_in  = (is_signed && dif.in_a[XLEN-1]) ? -dif.in_a : dif.in_a;
    assign abs_b_in  = (is_signed && dif.in_b[XLEN-1]) ? -dif.in_b : dif.in_b;

`ifdef DIV_EARLY_OUT_EN
    assign skip = (dif.in_b == '0) || (abs_b_in > abs_a_in);
`else
    assign skip = 1'b0;
`endif

    // rem < 2^31 while iterating, so dropping rem[31] from the shift loses nothing
    assign diff = {1'b0, rem[XLEN-2:0], quo[XLEN-1]} - {1'b0, abs_b};

    assign dif.in_ready  = (state_q == S_IDLE);
    assign dif.out_valid = (state_q == S_DONE);
    assign dif.busy      = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = !func3[2] ? S_DONE : (skip ? S_SIGN : S_CALC);
            S_CALC: if (cnt == '0) state_d = S_SIGN;
            S_SIGN: state_d = S_DONE;
            S_DONE: if (dif.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_raw      <= '0;
            abs_b      <= '0;
            quo        <= '0;
            rem        <= '0;
            cnt        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            b_zero     <= 1'b0;
            want_rem   <= 1'b0;
            dif.result <= '0;
        end else if (!flush) begin
            case (state_q)
                S_IDLE: if (accept) begin
                    a_raw    <= dif.in_a;
                    abs_b    <= abs_b_in;
                    quo      <= skip ? '0 : abs_a_in;
                    rem      <= skip ? abs_a_in : '0;
                    cnt      <= CNT_W'(XLEN - 1);
                    q_neg    <= is_signed & (dif.in_a[XLEN-1] ^ dif.in_b[XLEN-1]);
                    r_neg    <= is_signed & dif.in_a[XLEN-1];
                    b_zero   <= (dif.in_b == '0);
                    want_rem <= func3[1];
                    if (!func3[2]) dif.result <= '0;
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end
                S_SIGN: begin
                    if (b_zero)
                        dif.result <= want_rem ? a_raw : '1;
                    else if (want_rem)
                        dif.result <= r_neg ? -rem : rem;
                    else
                        dif.result <= q_neg ? -quo : quo;
                end
                default: ;
            endcase
        end
    end

endmodule
